// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle LEGv8-subset control sequencer.
// Owns IR, NZVC flags and every datapath strobe.
module cpu_control_fsm #(
  parameter int XFER_BYTES  = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  input  logic        alu_zero,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  input  logic        mem_ready,
  output logic        fetch_req,
  output logic        pc_en,
  output logic        BrTaken,
  output logic        UncondBr,
  output logic        Reg2Loc,
  output logic [1:0]  ALUSrc,
  output logic [2:0]  ALUOp,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic [3:0]  xfer_size,
  output logic [3:0]  flags,
  output logic        halted,
  output logic        illegal,
  output logic        mem_err
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;

  localparam int WW = $clog2(MEM_TIMEOUT + 2);

  logic [2:0]    r_state;
  logic [31:0]   r_ir;
  logic [3:0]    r_flags;
  logic [WW-1:0] r_wait;
  logic          r_illegal;
  logic          r_mem_err;

  logic w_halt, w_addi, w_adds, w_subs;
  logic w_ldur, w_stur, w_cbz, w_blt, w_b;
  logic w_alu, w_legal;

  assign w_halt = (r_ir == 32'h1400_0000);
  assign w_addi = (r_ir[31:22] == 10'b1001000100);
  assign w_adds = (r_ir[31:21] == 11'b10101011000);
  assign w_subs = (r_ir[31:21] == 11'b11101011000);
  assign w_ldur = (r_ir[31:21] == 11'b11111000010);
  assign w_stur = (r_ir[31:21] == 11'b11111000000);
  assign w_cbz  = (r_ir[31:24] == 8'b10110100);
  assign w_blt  = (r_ir[31:24] == 8'b01010100) &&
                  (r_ir[4:0] == 5'b01011);
  assign w_b    = (r_ir[31:26] == 6'b000101) && !w_halt;

  assign w_alu   = w_addi | w_adds | w_subs;
  assign w_legal = w_alu | w_ldur | w_stur | w_cbz |
                   w_blt | w_b | w_halt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_flags   <= '0;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (instr_valid) begin
            r_ir    <= instruction;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end else if (w_halt) begin
            r_state <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_wait <= '0;
          if (w_adds || w_subs)
            r_flags <= {alu_negative, alu_zero,
                        alu_overflow, alu_carry};
          if (w_ldur || w_stur)
            r_state <= S_MEM;
          else if (w_alu)
            r_state <= S_WB;
          else
            r_state <= S_FETCH;
        end
        S_MEM: begin
          // a ready on the final allowed cycle beats the timeout
          if (mem_ready) begin
            r_wait  <= '0;
            r_state <= w_ldur ? S_WB : S_FETCH;
          end else if (r_wait == WW'(MEM_TIMEOUT)) begin
            r_mem_err <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    fetch_req = 1'b0;
    pc_en     = 1'b0;
    BrTaken   = 1'b0;
    UncondBr  = 1'b0;
    Reg2Loc   = 1'b1;
    ALUSrc    = 2'b00;
    ALUOp     = OP_PASS;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemToReg  = 1'b0;
    RegWrite  = 1'b0;
    xfer_size = 4'd0;
    unique case (r_state)
      S_FETCH: fetch_req = reset_n;
      S_EXEC: begin
        unique case (1'b1)
          w_addi: begin
            ALUSrc = 2'b01;
            ALUOp  = OP_ADD;
          end
          w_adds: ALUOp = OP_ADD;
          w_subs: ALUOp = OP_SUB;
          w_ldur: begin
            ALUSrc    = 2'b10;
            ALUOp     = OP_ADD;
            xfer_size = 4'(XFER_BYTES);
          end
          w_stur: begin
            ALUSrc    = 2'b10;
            ALUOp     = OP_ADD;
            Reg2Loc   = 1'b0;
            xfer_size = 4'(XFER_BYTES);
          end
          w_cbz: begin
            Reg2Loc = 1'b0;
            ALUOp   = OP_PASS;
            BrTaken = alu_zero;
            pc_en   = 1'b1;
          end
          w_blt: begin
            BrTaken = r_flags[3] ^ r_flags[1];
            pc_en   = 1'b1;
          end
          w_b: begin
            BrTaken  = 1'b1;
            UncondBr = 1'b1;
            pc_en    = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ALUSrc    = 2'b10;
        ALUOp     = OP_ADD;
        xfer_size = 4'(XFER_BYTES);
        MemRead   = w_ldur;
        MemWrite  = w_stur;
        Reg2Loc   = !w_stur;
        pc_en     = w_stur && mem_ready;
      end
      S_WB: begin
        // ALU controls stay put so the result is still on the bus
        RegWrite = 1'b1;
        pc_en    = 1'b1;
        MemToReg = w_ldur;
        if (w_addi) ALUSrc = 2'b01;
        if (w_addi || w_adds) ALUOp = OP_ADD;
        if (w_subs) ALUOp = OP_SUB;
      end
      default: ;
    endcase
  end

  assign flags   = r_flags;
  assign halted  = (r_state == S_HALT);
  assign illegal = r_illegal;
  assign mem_err = r_mem_err;

endmodule
